// File: rtl/kuuga_mem_arbiter_nch.sv
// kuuga_mem_arbiter_nch
// Round-robin arbiter in front of one single-port, byte-writable memory.
// Each cycle at most one channel is granted; reads return through a
// READ_LATENCY-deep pipeline that carries the channel tag captured at grant,
// so responses come back in grant order at one per cycle.
// Misaligned or out-of-range accesses never touch the memory: writes report
// ch_err one cycle later, reads return ERR_FILL data with ch_err.
module kuuga_mem_arbiter_nch #(
  parameter int         NUM_CH       = 2,
  parameter int         ADDR_WIDTH   = 16,
  parameter int         DATA_WIDTH   = 32,
  parameter int         DEPTH_WORDS  = 32768,
  parameter int         READ_LATENCY = 1,
  parameter logic [7:0] ERR_FILL     = 8'hEE
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CH-1:0]              ch_req,
  input  logic [NUM_CH*(DATA_WIDTH/8)-1:0] ch_we,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   ch_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_wdata,
  output logic [NUM_CH-1:0]              ch_gnt,
  output logic [NUM_CH-1:0]              ch_rvalid,
  output logic [NUM_CH*DATA_WIDTH-1:0]   ch_rdata,
  output logic [NUM_CH-1:0]              ch_err
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int OFF_BITS = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int MEM_AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int LAST     = READ_LATENCY - 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic [CH_W-1:0]       ptr;
  logic                  gnt_any;
  logic [CH_W-1:0]       gnt_ch;
  logic [CH_W:0]         cand_sum;
  logic [CH_W-1:0]       cand;

  logic [BYTES-1:0]      sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [31:0]           sel_idx;
  logic [MEM_AW-1:0]     mem_idx;
  logic                  sel_write;
  logic                  sel_bad;

  logic                  pipe_valid [READ_LATENCY];
  logic                  pipe_err   [READ_LATENCY];
  logic [CH_W-1:0]       pipe_ch    [READ_LATENCY];
  logic [DATA_WIDTH-1:0] pipe_data  [READ_LATENCY];
  logic [NUM_CH-1:0]     wr_err;

  // Pick the first requesting channel at or after the pointer; nothing is granted in reset.
  always_comb begin
    ch_gnt   = '0;
    gnt_any  = 1'b0;
    gnt_ch   = '0;
    cand_sum = '0;
    cand     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand_sum = {1'b0, ptr} + (CH_W+1)'(i);
      if (cand_sum >= (CH_W+1)'(NUM_CH)) begin
        cand_sum = cand_sum - (CH_W+1)'(NUM_CH);
      end
      cand = cand_sum[CH_W-1:0];
      if (!gnt_any && reset && ch_req[cand]) begin
        gnt_any = 1'b1;
        gnt_ch  = cand;
      end
    end
    if (gnt_any) begin
      ch_gnt[gnt_ch] = 1'b1;
    end
  end

  // Steer the granted channel's command onto the memory port and classify it.
  always_comb begin
    sel_we    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (gnt_ch == CH_W'(k)) begin
        sel_we    = ch_we[k*BYTES +: BYTES];
        sel_addr  = ch_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = ch_wdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    sel_idx   = 32'(sel_addr) >> OFF_BITS;
    mem_idx   = sel_idx[MEM_AW-1:0];
    sel_write = |sel_we;
    sel_bad   = ((sel_addr & ADDR_WIDTH'(BYTES-1)) != '0) ||
                (sel_idx >= 32'(DEPTH_WORDS));
  end

  // Round-robin pointer moves just past the channel that was granted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (gnt_ch == CH_W'(NUM_CH-1)) ? '0 : gnt_ch + 1'b1;
    end
  end

  // Byte-masked memory write at the grant edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (gnt_any && sel_write && !sel_bad) begin
      for (int b = 0; b < BYTES; b++) begin
        if (sel_we[b]) begin
          mem[mem_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read pipeline (old memory contents, so reads see data before a same-edge write) plus write-error flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < READ_LATENCY; s++) begin
        pipe_valid[s] <= 1'b0;
        pipe_err[s]   <= 1'b0;
        pipe_ch[s]    <= '0;
        pipe_data[s]  <= '0;
      end
      wr_err <= '0;
    end else begin
      pipe_valid[0] <= gnt_any && !sel_write;
      pipe_err[0]   <= sel_bad;
      pipe_ch[0]    <= gnt_ch;
      pipe_data[0]  <= sel_bad ? {BYTES{ERR_FILL}} : mem[mem_idx];
      for (int s = 1; s < READ_LATENCY; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        pipe_err[s]   <= pipe_err[s-1];
        pipe_ch[s]    <= pipe_ch[s-1];
        pipe_data[s]  <= pipe_data[s-1];
      end
      wr_err <= (gnt_any && sel_write && sel_bad) ? ch_gnt : '0;
    end
  end

  // Route the final pipeline stage to the tagged channel; merge write errors.
  always_comb begin
    ch_rvalid = '0;
    ch_err    = wr_err;
    ch_rdata  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (pipe_valid[LAST] && (pipe_ch[LAST] == CH_W'(k))) begin
        ch_rvalid[k] = 1'b1;
        ch_err[k]    = ch_err[k] | pipe_err[LAST];
        ch_rdata[k*DATA_WIDTH +: DATA_WIDTH] = pipe_data[LAST];
      end
    end
  end

endmodule

// File: tb/tb_kuuga_mem_arbiter_nch.sv
// Directed bench for kuuga_mem_arbiter_nch: two channels, 32-bit words,
// 1024-word memory, three-cycle read latency.
module tb_kuuga_mem_arbiter_nch;

  logic        clk;
  logic        reset;
  logic [1:0]  ch_req;
  logic [7:0]  ch_we;
  logic [31:0] ch_addr;
  logic [63:0] ch_wdata;
  logic [1:0]  ch_gnt;
  logic [1:0]  ch_rvalid;
  logic [63:0] ch_rdata;
  logic [1:0]  ch_err;

  int tests_run;
  int tests_failed;

  kuuga_mem_arbiter_nch #(
    .NUM_CH(2),
    .ADDR_WIDTH(16),
    .DATA_WIDTH(32),
    .DEPTH_WORDS(1024),
    .READ_LATENCY(3),
    .ERR_FILL(8'hEE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ch_req(ch_req),
    .ch_we(ch_we),
    .ch_addr(ch_addr),
    .ch_wdata(ch_wdata),
    .ch_gnt(ch_gnt),
    .ch_rvalid(ch_rvalid),
    .ch_rdata(ch_rdata),
    .ch_err(ch_err)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a hung run
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic set_ch(input int ch, input logic req, input logic [3:0] we,
                        input logic [15:0] addr, input logic [31:0] wdata);
    if (ch == 0) begin
      ch_req[0] = req; ch_we[3:0] = we; ch_addr[15:0] = addr; ch_wdata[31:0] = wdata;
    end else begin
      ch_req[1] = req; ch_we[7:4] = we; ch_addr[31:16] = addr; ch_wdata[63:32] = wdata;
    end
  endtask

  task automatic idle();
    ch_req = 2'b00;
    ch_we  = 8'h00;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_ch(0, 1'b1, 4'hF, 16'h0040, 32'h55555555);
    set_ch(1, 1'b1, 4'h0, 16'h0044, 32'h0);
    repeat (3) next_cycle();
    #1;
    tests_run++;
    if (ch_gnt !== 2'b00) begin tests_failed++; $display("[TB] FAIL rst_gnt: got %b expected %b", ch_gnt, 2'b00); end
    tests_run++;
    if (ch_rvalid !== 2'b00) begin tests_failed++; $display("[TB] FAIL rst_rvalid: got %b expected %b", ch_rvalid, 2'b00); end
    tests_run++;
    if (ch_err !== 2'b00) begin tests_failed++; $display("[TB] FAIL rst_err: got %b expected %b", ch_err, 2'b00); end
    tests_run++;
    if (ch_rdata !== 64'h0) begin tests_failed++; $display("[TB] FAIL rst_rdata: got %h expected %h", ch_rdata, 64'h0); end
    next_cycle();
    idle();
    reset = 1'b1;
    next_cycle();
    #1;
    tests_run++;
    if (ch_rvalid !== 2'b00) begin tests_failed++; $display("[TB] FAIL rst_rel_rvalid: got %b expected %b", ch_rvalid, 2'b00); end
    next_cycle();
  endtask

  task automatic test_write_read();
    set_ch(0, 1'b1, 4'hF, 16'h0010, 32'hDEADBEEF);
    #1;
    tests_run++;
    if (ch_gnt !== 2'b01) begin tests_failed++; $display("[TB] FAIL wr_gnt: got %b expected %b", ch_gnt, 2'b01); end
    next_cycle();
    set_ch(0, 1'b1, 4'h0, 16'h0010, 32'h0);
    #1;
    tests_run++;
    if (ch_gnt !== 2'b01) begin tests_failed++; $display("[TB] FAIL rd_gnt: got %b expected %b", ch_gnt, 2'b01); end
    next_cycle();
    idle();
    for (int c = 2; c <= 5; c++) begin
      #1;
      tests_run++;
      if (ch_rvalid !== ((c == 4) ? 2'b01 : 2'b00)) begin
        tests_failed++;
        $display("[TB] FAIL wrrd_rvalid c%0d: got %b expected %b", c, ch_rvalid, (c == 4) ? 2'b01 : 2'b00);
      end
      tests_run++;
      if (ch_err !== 2'b00) begin tests_failed++; $display("[TB] FAIL wrrd_err c%0d: got %b expected %b", c, ch_err, 2'b00); end
      if (c == 4) begin
        tests_run++;
        if (ch_rdata[31:0] !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL wrrd_data: got %h expected %h", ch_rdata[31:0], 32'hDEADBEEF); end
      end
      next_cycle();
    end
  endtask

  task automatic test_byte_enable();
    logic [3:0]  we_t [3] = '{4'hF, 4'b0010, 4'h0};
    logic [31:0] wd_t [3] = '{32'h11223344, 32'h0000AB00, 32'h0};
    for (int c = 0; c <= 6; c++) begin
      if (c < 3) set_ch(1, 1'b1, we_t[c], 16'h0020, wd_t[c]);
      else idle();
      #1;
      tests_run++;
      if (ch_gnt !== ((c < 3) ? 2'b10 : 2'b00)) begin
        tests_failed++;
        $display("[TB] FAIL be_gnt c%0d: got %b expected %b", c, ch_gnt, (c < 3) ? 2'b10 : 2'b00);
      end
      if (c >= 3) begin
        tests_run++;
        if (ch_rvalid !== ((c == 5) ? 2'b10 : 2'b00)) begin
          tests_failed++;
          $display("[TB] FAIL be_rvalid c%0d: got %b expected %b", c, ch_rvalid, (c == 5) ? 2'b10 : 2'b00);
        end
      end
      if (c == 5) begin
        tests_run++;
        if (ch_rdata[63:32] !== 32'h1122AB44) begin tests_failed++; $display("[TB] FAIL be_data: got %h expected %h", ch_rdata[63:32], 32'h1122AB44); end
      end
      next_cycle();
    end
  endtask

  task automatic test_round_robin();
    int cnt0 = 0;
    int cnt1 = 0;
    logic [1:0] exp_gnt;
    logic [1:0] exp_rv;
    for (int c = 0; c <= 8; c++) begin
      if (c < 6) begin
        set_ch(0, 1'b1, 4'h0, 16'h0010, 32'h0);
        set_ch(1, 1'b1, 4'h0, 16'h0020, 32'h0);
      end else begin
        idle();
      end
      #1;
      exp_gnt = (c < 6) ? ((c % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_rv  = (c >= 3) ? (((c - 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      tests_run++;
      if (ch_gnt !== exp_gnt) begin tests_failed++; $display("[TB] FAIL rr_gnt c%0d: got %b expected %b", c, ch_gnt, exp_gnt); end
      tests_run++;
      if (ch_rvalid !== exp_rv) begin tests_failed++; $display("[TB] FAIL rr_rvalid c%0d: got %b expected %b", c, ch_rvalid, exp_rv); end
      if (exp_rv == 2'b01) begin
        tests_run++;
        if (ch_rdata[31:0] !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL rr_data0 c%0d: got %h expected %h", c, ch_rdata[31:0], 32'hDEADBEEF); end
      end
      if (exp_rv == 2'b10) begin
        tests_run++;
        if (ch_rdata[63:32] !== 32'h1122AB44) begin tests_failed++; $display("[TB] FAIL rr_data1 c%0d: got %h expected %h", c, ch_rdata[63:32], 32'h1122AB44); end
      end
      if (ch_rvalid[0] === 1'b1) cnt0++;
      if (ch_rvalid[1] === 1'b1) cnt1++;
      next_cycle();
    end
    tests_run++;
    if (cnt0 != 3) begin tests_failed++; $display("[TB] FAIL rr_count0: got %0d expected %0d", cnt0, 3); end
    tests_run++;
    if (cnt1 != 3) begin tests_failed++; $display("[TB] FAIL rr_count1: got %0d expected %0d", cnt1, 3); end
  endtask

  task automatic test_errors();
    logic [3:0]  we_t  [7]  = '{4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [15:0] ad_t  [7]  = '{16'h0000, 16'h0012, 16'h1000, 16'h0006, 16'h1000, 16'h0010, 16'h0000};
    logic [31:0] wd_t  [7]  = '{32'h01020304, 32'h00000000, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [1:0]  err_t [10] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    logic [1:0]  rv_t  [10] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
    logic [31:0] rd_t  [10] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                32'hEEEEEEEE, 32'hEEEEEEEE, 32'hDEADBEEF, 32'h01020304};
    for (int c = 0; c <= 9; c++) begin
      if (c < 7) set_ch(0, 1'b1, we_t[c], ad_t[c], wd_t[c]);
      else idle();
      #1;
      tests_run++;
      if (ch_gnt !== ((c < 7) ? 2'b01 : 2'b00)) begin
        tests_failed++;
        $display("[TB] FAIL err_gnt c%0d: got %b expected %b", c, ch_gnt, (c < 7) ? 2'b01 : 2'b00);
      end
      tests_run++;
      if (ch_err !== err_t[c]) begin tests_failed++; $display("[TB] FAIL err_flag c%0d: got %b expected %b", c, ch_err, err_t[c]); end
      tests_run++;
      if (ch_rvalid !== rv_t[c]) begin tests_failed++; $display("[TB] FAIL err_rvalid c%0d: got %b expected %b", c, ch_rvalid, rv_t[c]); end
      if (rv_t[c] != 2'b00) begin
        tests_run++;
        if (ch_rdata[31:0] !== rd_t[c]) begin tests_failed++; $display("[TB] FAIL err_data c%0d: got %h expected %h", c, ch_rdata[31:0], rd_t[c]); end
      end
      next_cycle();
    end
  endtask

  task automatic test_same_word();
    logic [1:0] gnt_t [7] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
    logic [1:0] rv_t  [7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10};
    for (int c = 0; c <= 6; c++) begin
      idle();
      if (c == 0) set_ch(0, 1'b1, 4'hF, 16'h0030, 32'h12345678);
      if (c == 1 || c == 2) set_ch(0, 1'b1, 4'hF, 16'h0030, 32'h9ABCDEF0);
      if (c == 1 || c == 3) set_ch(1, 1'b1, 4'h0, 16'h0030, 32'h0);
      #1;
      tests_run++;
      if (ch_gnt !== gnt_t[c]) begin tests_failed++; $display("[TB] FAIL sw_gnt c%0d: got %b expected %b", c, ch_gnt, gnt_t[c]); end
      tests_run++;
      if (ch_rvalid !== rv_t[c]) begin tests_failed++; $display("[TB] FAIL sw_rvalid c%0d: got %b expected %b", c, ch_rvalid, rv_t[c]); end
      if (c == 4) begin
        tests_run++;
        if (ch_rdata[63:32] !== 32'h12345678) begin tests_failed++; $display("[TB] FAIL sw_old: got %h expected %h", ch_rdata[63:32], 32'h12345678); end
      end
      if (c == 6) begin
        tests_run++;
        if (ch_rdata[63:32] !== 32'h9ABCDEF0) begin tests_failed++; $display("[TB] FAIL sw_new: got %h expected %h", ch_rdata[63:32], 32'h9ABCDEF0); end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_flush();
    logic [1:0] gnt_t [9] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
    logic [1:0] rv_t  [9] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
    for (int c = 0; c <= 8; c++) begin
      idle();
      reset = (c == 2 || c == 3) ? 1'b0 : 1'b1;
      if (c == 0) set_ch(0, 1'b1, 4'h0, 16'h0010, 32'h0);
      if (c == 1) set_ch(0, 1'b1, 4'h0, 16'h0020, 32'h0);
      if (c == 2 || c == 3) begin
        set_ch(0, 1'b1, 4'hF, 16'h0010, 32'h00000000);
        set_ch(1, 1'b1, 4'h0, 16'h0020, 32'h0);
      end
      if (c == 4) begin
        set_ch(0, 1'b1, 4'h0, 16'h0010, 32'h0);
        set_ch(1, 1'b1, 4'h0, 16'h0020, 32'h0);
      end
      if (c == 5) set_ch(1, 1'b1, 4'h0, 16'h0020, 32'h0);
      #1;
      tests_run++;
      if (ch_gnt !== gnt_t[c]) begin tests_failed++; $display("[TB] FAIL fl_gnt c%0d: got %b expected %b", c, ch_gnt, gnt_t[c]); end
      tests_run++;
      if (ch_rvalid !== rv_t[c]) begin tests_failed++; $display("[TB] FAIL fl_rvalid c%0d: got %b expected %b", c, ch_rvalid, rv_t[c]); end
      if (c == 3) begin
        tests_run++;
        if (ch_rdata !== 64'h0) begin tests_failed++; $display("[TB] FAIL fl_rdata: got %h expected %h", ch_rdata, 64'h0); end
        tests_run++;
        if (ch_err !== 2'b00) begin tests_failed++; $display("[TB] FAIL fl_err: got %b expected %b", ch_err, 2'b00); end
      end
      if (c == 7) begin
        tests_run++;
        if (ch_rdata[31:0] !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL fl_data0: got %h expected %h", ch_rdata[31:0], 32'hDEADBEEF); end
      end
      if (c == 8) begin
        tests_run++;
        if (ch_rdata[63:32] !== 32'h1122AB44) begin tests_failed++; $display("[TB] FAIL fl_data1: got %h expected %h", ch_rdata[63:32], 32'h1122AB44); end
      end
      next_cycle();
    end
    idle();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset    = 1'b0;
    ch_req   = 2'b00;
    ch_we    = 8'h00;
    ch_addr  = 32'h0;
    ch_wdata = 64'h0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_byte_enable();
    test_round_robin();
    test_errors();
    test_same_word();
    test_reset_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/kuuga_mem_arbiter_nch.md
KUUGA_MEM_ARBITER_NCH -- requirements
Module: kuuga_mem_arbiter_nch

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 2, meaning the number of requesting channels (1..8).
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 16, meaning the channel byte-address width.
REQ-003 The module SHALL have parameter DATA_WIDTH, default 32, meaning the word width; a multiple of 8, with BYTES = DATA_WIDTH/8.
REQ-004 The module SHALL have parameter DEPTH_WORDS, default 32768, meaning the number of memory words.
REQ-005 The module SHALL have parameter READ_LATENCY, default 1, meaning the cycles from grant to read data (1..4).
REQ-006 The module SHALL have parameter ERR_FILL, default 8'hEE, meaning the byte pattern returned on errored reads.
REQ-007 clk  in  1  single clock; all logic is on the rising edge.
REQ-008 reset  in  1  synchronous, active-low reset.
REQ-009 ch_req  in  NUM_CH  per-channel request; held until granted.
REQ-010 ch_we  in  NUM_CH*BYTES  per-channel byte write enables; all zero means read.
REQ-011 ch_addr  in  NUM_CH*ADDR_WIDTH  per-channel byte address.
REQ-012 ch_wdata  in  NUM_CH*DATA_WIDTH  per-channel write data.
REQ-013 ch_gnt  out  NUM_CH  one-hot grant pulse; the request is accepted this cycle.
REQ-014 ch_rvalid  out  NUM_CH  read-data-valid pulse.
REQ-015 ch_rdata  out  NUM_CH*DATA_WIDTH  per-channel read data; valid only while the matching ch_rvalid is high.
REQ-016 ch_err  out  NUM_CH  error pulse, coincident with that channel's response.

Function
REQ-017 The module SHALL contain one internal single-port memory (DEPTH_WORDS x DATA_WIDTH) that is not cleared by reset.
REQ-018 The module SHALL perform at most one access per cycle and assert at most one ch_gnt bit per cycle, combinationally in the same cycle as the selected ch_req.
REQ-019 Arbitration SHALL be round-robin: search starts at pointer P; after a grant to channel k, P becomes (k+1) mod NUM_CH; with no grant, P is unchanged.
REQ-020 A granted request SHALL use word index = ch_addr >> log2(BYTES).
REQ-021 Write (any ch_we bit set): only the enabled bytes are written at the grant edge; there is no ch_rvalid; ch_err pulses one cycle after the grant if an error occurs.
REQ-022 Read: ch_rvalid[k] and ch_rdata[k] SHALL appear exactly READ_LATENCY cycles after ch_gnt[k], with the data read-first relative to any same-cycle write.
REQ-023 Back-to-back grants SHALL be fully pipelined, giving one response per cycle sustained.
REQ-024 Misaligned address (low log2(BYTES) bits nonzero) SHALL be an error: no memory access; a read returns ERR_FILL-replicated data with ch_rvalid and ch_err high.
REQ-025 An out-of-range word index (>= DEPTH_WORDS) SHALL be treated the same as a misaligned address.
REQ-026 Responses SHALL be delivered in grant order, and each response SHALL carry the channel tag captured at grant.
REQ-027 A channel dropping ch_req before it is granted SHALL be legal; its request is abandoned.

Reset
REQ-028 While reset=0 at a clock edge, the module SHALL set ch_gnt=0, ch_rvalid=0, ch_err=0, ch_rdata=0, and P=0, and no memory write occurs.
REQ-029 Reset asserted mid-operation SHALL flush all in-flight reads; no ch_rvalid is produced for them after reset is released.
REQ-030 The first cycle after reset release SHALL accept requests normally.

Verification
REQ-031 Channel 0 writes 0xDEADBEEF to address 0x0010, then reads 0x0010 -> ch_rvalid[0] READ_LATENCY cycles after the grant, with ch_rdata=0xDEADBEEF and ch_err=0.
REQ-032 ch_we=4'b0010 with wdata 0x0000AB00 over a word holding 0x11223344, then a read -> returns 0x1122AB44.
REQ-033 Both channels hold ch_req for 6 cycles, P=0 -> grants alternate 0,1,0,1,0,1 and each channel receives 3 in-order responses.
REQ-034 Read of address 0x0006, then read of byte address 4*DEPTH_WORDS -> each returns 0xEEEEEEEE with ch_err=1 and the memory unchanged.
REQ-035 With READ_LATENCY=3, reset is asserted one cycle after the grant of two pipelined reads -> no ch_rvalid ever appears for them, and P=0 after reset.
REQ-036 A same-cycle write and read on the same word across consecutive grants -> the read observes the value before or after the write strictly per grant order.
